pe_mac_db: RTL

Parametrised weight-stationary processing element for the systolic array. It has a double-buffered weight: the next weight loads into a shadow register while the active weight keeps computing, and a swap promotes the shadow without a pipeline bubble. Each cycle it computes psum_o = psum_i + W·x with configurable widths and an optional saturating accumulate. All controls are forwarded one cycle to the neighbouring PEs, so the block tiles directly into the array.

---
 rtl/pe_pkg.sv | 26 ++
 rtl/pe_mac_db_if.sv | 40 ++++
 rtl/pe_sat_add.sv | 40 ++++
 rtl/pe_mac_db.sv | 131 +++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// pe_pkg: shared definitions for the weight-stationary PE.
//   - default parameter constants
//   - shadow weight register state enum
//   - saturation bound helpers for an AW-bit signed value
package pe_pkg;

  localparam int DW_DEF  = 8;
  localparam int WW_DEF  = 8;
  localparam int AW_DEF  = 20;
  localparam int SAT_DEF = 1;

  typedef enum logic {
    SH_EMPTY = 1'b0,
    SH_FULL  = 1'b1
  } sh_state_e;

  // Largest / smallest representable value of an aw-bit signed number.
  function automatic logic signed [63:0] sat_max(input int aw);
    return (64'sd1 <<< (aw - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int aw);
    return -(64'sd1 <<< (aw - 1));
  endfunction

endpackage

// File: rtl/pe_mac_db_if.sv
// pe_mac_db_if: data/control bundle of one PE.
//   Inputs from neighbours: x_i, x_vld_i, w_i, w_ld_i, w_swap_i, row_en_i, psum_i
//   Outputs: forwarded x/w controls, psum_o/psum_vld_o, w_rdy_o, ovf_o
//   slave  = PE side, master = driver (neighbour / bench) side.
interface pe_mac_db_if #(
  parameter int DW = 8,
  parameter int WW = 8,
  parameter int AW = 20
);
  logic signed [DW-1:0] x_i;
  logic                 x_vld_i;
  logic signed [WW-1:0] w_i;
  logic                 w_ld_i;
  logic                 w_swap_i;
  logic                 row_en_i;
  logic signed [AW-1:0] psum_i;

  logic signed [DW-1:0] x_o;
  logic                 x_vld_o;
  logic signed [WW-1:0] w_o;
  logic                 w_ld_o;
  logic                 w_swap_o;
  logic                 row_en_o;
  logic signed [AW-1:0] psum_o;
  logic                 psum_vld_o;
  logic                 w_rdy_o;
  logic                 ovf_o;

  modport slave (
    input  x_i, x_vld_i, w_i, w_ld_i, w_swap_i, row_en_i, psum_i,
    output x_o, x_vld_o, w_o, w_ld_o, w_swap_o, row_en_o,
           psum_o, psum_vld_o, w_rdy_o, ovf_o
  );

  modport master (
    output x_i, x_vld_i, w_i, w_ld_i, w_swap_i, row_en_i, psum_i,
    input  x_o, x_vld_o, w_o, w_ld_o, w_swap_o, row_en_o,
           psum_o, psum_vld_o, w_rdy_o, ovf_o
  );
endinterface

// File: rtl/pe_sat_add.sv
// pe_sat_add: combinational AW-bit signed accumulate.
//   a, b : AW-bit signed operands (psum and sign-extended product)
//   sum  : AW-bit result, clamped (SAT=1) or wrapped (SAT=0)
//   ovf  : pulse when clamping (SAT=1) or signed overflow (SAT=0) occurs
module pe_sat_add import pe_pkg::*; #(
  parameter int AW  = AW_DEF,
  parameter int SAT = SAT_DEF
) (
  input  logic signed [AW-1:0] a,
  input  logic signed [AW-1:0] b,
  output logic signed [AW-1:0] sum,
  output logic                 ovf
);

  generate
    if (SAT != 0) begin : g_sat
      localparam logic signed [63:0] MAX64 = sat_max(AW);
      localparam logic signed [63:0] MIN64 = sat_min(AW);
      logic signed [AW:0] wide;

      // One guard bit is enough for the sum of two AW-bit values.
      always_comb begin
        wide = {a[AW-1], a} + {b[AW-1], b};
        sum  = wide[AW-1:0];
        ovf  = 1'b0;
        if (wide > (AW+1)'(MAX64)) begin
          sum = MAX64[AW-1:0];
          ovf = 1'b1;
        end else if (wide < (AW+1)'(MIN64)) begin
          sum = MIN64[AW-1:0];
          ovf = 1'b1;
        end
      end
    end else begin : g_wrap
      assign sum = a + b;
      assign ovf = (a[AW-1] == b[AW-1]) && (sum[AW-1] != a[AW-1]);
    end
  endgenerate

endmodule

// File: rtl/pe_mac_db.sv
// pe_mac_db: weight-stationary MAC processing element with a double-buffered
// weight. psum_o = psum_i + act_w * x_i (1-cycle latency), or a bypass when no
// weight is active or the row is disabled. The shadow register takes loads
// while the active weight keeps computing; a swap promotes it bubble-free.
//   CLK : clock (rising edge)
//   RST : synchronous active-high reset
//   io  : pe_mac_db_if.slave, all neighbour-facing data and controls
module pe_mac_db import pe_pkg::*; #(
  parameter int DW  = DW_DEF,
  parameter int WW  = WW_DEF,
  parameter int AW  = AW_DEF,
  parameter int SAT = SAT_DEF
) (
  input logic         CLK,
  input logic         RST,
  pe_mac_db_if.slave  io
);

  generate
    if (AW < DW + WW) begin : g_bad_aw
      $error("pe_mac_db: AW must be >= DW+WW");
    end
  endgenerate

  // weight state
  sh_state_e            sh_q, sh_nxt;
  logic signed [WW-1:0] sh_w;
  logic signed [WW-1:0] act_w;
  logic                 act_vld;
  logic                 do_swap;

  // datapath state
  logic signed [AW-1:0] psum_q;
  logic                 psum_vld_q;
  logic                 ovf_q;

  // forwarded controls
  logic signed [DW-1:0] x_q;
  logic                 x_vld_q;
  logic signed [WW-1:0] w_q;
  logic                 w_ld_q, w_swap_q, row_en_q;

  // Shadow FSM. A swap only takes effect from FULL; a load always lands.
  always_comb begin
    sh_nxt  = sh_q;
    do_swap = 1'b0;
    case (sh_q)
      SH_EMPTY: begin
        if (io.w_ld_i) sh_nxt = SH_FULL;
      end
      SH_FULL: begin
        do_swap = io.w_swap_i;
        if (io.w_swap_i && !io.w_ld_i) sh_nxt = SH_EMPTY;
      end
      default: sh_nxt = SH_EMPTY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sh_q    <= SH_EMPTY;
      sh_w    <= '0;
      act_w   <= '0;
      act_vld <= 1'b0;
    end else begin
      sh_q <= sh_nxt;
      if (io.w_ld_i) sh_w <= io.w_i;
      // act_w takes the pre-load shadow value even when a load lands together.
      if (do_swap) begin
        act_w   <= sh_w;
        act_vld <= 1'b1;
      end
    end
  end

  // MAC: uses the current act_w, so a same-cycle swap still sees the old one.
  logic signed [DW+WW-1:0] prod;
  logic signed [AW-1:0]    prod_ext;
  logic signed [AW-1:0]    sum;
  logic                    add_ovf;
  logic                    mac_en;

  assign prod     = (DW+WW)'(io.x_i) * (DW+WW)'(act_w);
  assign prod_ext = AW'(prod);
  assign mac_en   = act_vld & io.row_en_i;

  pe_sat_add #(.AW(AW), .SAT(SAT)) u_add (
    .a   (io.psum_i),
    .b   (prod_ext),
    .sum (sum),
    .ovf (add_ovf)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      psum_q     <= '0;
      psum_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
      x_q        <= '0;
      x_vld_q    <= 1'b0;
      w_q        <= '0;
      w_ld_q     <= 1'b0;
      w_swap_q   <= 1'b0;
      row_en_q   <= 1'b0;
    end else begin
      psum_vld_q <= io.x_vld_i;
      if (io.x_vld_i) begin
        psum_q <= mac_en ? sum : io.psum_i;
        if (mac_en && add_ovf) ovf_q <= 1'b1;
      end
      x_q      <= io.x_i;
      x_vld_q  <= io.x_vld_i;
      w_q      <= io.w_i;
      w_ld_q   <= io.w_ld_i;
      w_swap_q <= io.w_swap_i;
      row_en_q <= io.row_en_i;
    end
  end

  assign io.psum_o     = psum_q;
  assign io.psum_vld_o = psum_vld_q;
  assign io.ovf_o      = ovf_q;
  assign io.w_rdy_o    = (sh_q == SH_EMPTY);
  assign io.x_o        = x_q;
  assign io.x_vld_o    = x_vld_q;
  assign io.w_o        = w_q;
  assign io.w_ld_o     = w_ld_q;
  assign io.w_swap_o   = w_swap_q;
  assign io.row_en_o   = row_en_q;

endmodule
